// File: rtl/vme_cmd_responder.sv
// Far end of the VME command-register path: decodes one command word, runs a single
// internal register-bus access with a bounded acknowledge wait, and returns a tagged status word.
module vme_cmd_responder #(
   parameter int unsigned TIMEOUT = 1000,
   parameter logic [7:0]  SIG     = 8'hA8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [31:0] i_vme_cmd_reg,
   input  logic [31:0] i_vme_dat_reg_in,
   output logic        o_vme_cmd_rd,
   output logic        o_vme_dat_wr,
   output logic [31:0] o_vme_dat_reg_out,
   output logic [15:0] o_dev_addr,
   output logic [15:0] o_dev_wdata,
   output logic        o_dev_we,
   output logic        o_dev_strobe,
   input  logic [15:0] i_dev_rdata,
   input  logic        i_dev_ack,
   output logic [1:0]  o_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      r_state;
   logic        r_cmd_rd;
   logic        r_dat_wr;
   logic [31:0] r_dat_out;
   logic [15:0] r_dev_addr;
   logic [15:0] r_dev_wdata;
   logic        r_dev_we;
   logic        r_dev_strobe;
   logic        r_is_read;
   logic [15:0] r_wait;
   logic [7:0]  r_seq;

   logic w_cmd_valid;
   logic w_wait_done;
   logic w_unused_bits;

   // Handshake: a command is taken on any edge where i_start=1 and o_vme_cmd_rd=1;
   // o_vme_dat_wr marks the single cycle in which o_vme_dat_reg_out is new.
   assign w_cmd_valid   = (i_vme_cmd_reg[23:16] == SIG) && (i_vme_cmd_reg[25] ^ i_vme_cmd_reg[24]);
   assign w_wait_done   = (r_wait == LP_WAIT_LAST);
   assign w_unused_bits = ^{i_vme_cmd_reg[31:26], i_vme_dat_reg_in[31:16]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cmd_rd     <= 1'b1;
         r_dat_wr     <= 1'b0;
         r_dat_out    <= 32'h0;
         r_dev_addr   <= 16'h0;
         r_dev_wdata  <= 16'h0;
         r_dev_we     <= 1'b0;
         r_dev_strobe <= 1'b0;
         r_is_read    <= 1'b0;
         r_wait       <= 16'h0;
         r_seq        <= 8'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_dev_addr  <= i_vme_cmd_reg[15:0];
                  r_dev_wdata <= i_vme_dat_reg_in[15:0];
                  r_dev_we    <= i_vme_cmd_reg[24];
                  r_is_read   <= i_vme_cmd_reg[25];
                  r_cmd_rd    <= 1'b0;
                  if (w_cmd_valid) begin
                     r_state      <= S_ACCESS;
                     r_dev_strobe <= 1'b1;
                     r_wait       <= 16'h0;
                  end else begin
                     // Rejected commands never touch the bus and report with was-read clear.
                     r_state   <= S_RESP;
                     r_dat_wr  <= 1'b1;
                     r_dat_out <= {r_seq, 5'b0, 1'b0, 1'b1, 1'b0, 16'h0};
                  end
               end
            end
            S_ACCESS: begin
               if (i_dev_ack) begin
                  r_state      <= S_RESP;
                  r_dev_strobe <= 1'b0;
                  r_dat_wr     <= 1'b1;
                  r_dat_out    <= {r_seq, 5'b0, r_is_read, 2'b00,
                                   (r_is_read ? i_dev_rdata : r_dev_wdata)};
               end else if (w_wait_done) begin
                  r_state      <= S_RESP;
                  r_dev_strobe <= 1'b0;
                  r_dat_wr     <= 1'b1;
                  r_dat_out    <= {r_seq, 5'b0, r_is_read, 1'b0, 1'b1, 16'h0};
               end else begin
                  r_wait <= r_wait + 16'd1;
               end
            end
            S_RESP: begin
               r_state  <= S_IDLE;
               r_dat_wr <= 1'b0;
               r_cmd_rd <= 1'b1;
               r_seq    <= r_seq + 8'd1;
            end
            default: begin
               r_state      <= S_IDLE;
               r_dat_wr     <= 1'b0;
               r_dev_strobe <= 1'b0;
               r_cmd_rd     <= 1'b1;
            end
         endcase
      end
   end

   assign o_vme_cmd_rd      = r_cmd_rd;
   assign o_vme_dat_wr      = r_dat_wr;
   assign o_vme_dat_reg_out = r_dat_out;
   assign o_dev_addr        = r_dev_addr;
   assign o_dev_wdata       = r_dev_wdata;
   assign o_dev_we          = r_dev_we;
   assign o_dev_strobe      = r_dev_strobe;
   assign o_state           = r_state;

endmodule
